uart_pkt_multi_decoder: RTL and testbench



---
 rtl/uart_pkt_pkg.sv | 26 ++
 rtl/uart_pkt_if.sv | 16 +
 rtl/uart_pkt_id_match.sv | 26 ++
 rtl/uart_pkt_multi_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_uart_pkt_multi_decoder.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet decoder.
// State encoding, error codes and stats counter width.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    S_HEADER = 3'd0,
    S_IDENT  = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_FOOTER = 3'd4,
    S_CHECK  = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_CSUM    = 3'b001;
  localparam logic [2:0] ERR_FOOTER  = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_ID      = 3'b100;

  localparam int STAT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_if.sv
// UART Rx byte stream bundle: byte plus one-cycle valid strobe.
// The byte source drives master, the decoder consumes slave.
interface uart_pkt_if;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;

  modport master (
    output uart_rx_data,
    output uart_rx_valid
  );

  modport slave (
    input uart_rx_data,
    input uart_rx_valid
  );
endinterface

// File: rtl/uart_pkt_id_match.sv
// Combinational priority matcher of a byte against an ID table.
// Lowest matching table index wins.
module uart_pkt_id_match #(
  parameter int NUM_IDS = 4,
  parameter int IW      = 2
) (
  input  logic [7:0]           i_byte,
  input  logic [NUM_IDS*8-1:0] i_id_list,
  input  logic [7:0]           i_mask,
  output logic                 o_hit,
  output logic [IW-1:0]        o_idx
);

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    // scan downwards so the lowest hit is written last
    for (int k = NUM_IDS - 1; k >= 0; k--) begin
      if (((i_byte ^ i_id_list[8*k +: 8]) & i_mask) == 8'h00) begin
        o_hit = 1'b1;
        o_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_pkt_multi_decoder.sv
// UART Rx packet decoder: header, id (table match), payload, csum, footer.
// Define UART_PKT_STATS_EN to add good/error packet counters.
module uart_pkt_multi_decoder
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0]           HEADER         = 8'hAA,
  parameter logic [7:0]           FOOTER         = 8'h55,
  parameter int                   PAYLOAD_BYTES  = 30,
  parameter int                   NUM_IDS        = 4,
  parameter logic [NUM_IDS*8-1:0] ID_LIST        =
    {8'h0F, 8'h0E, 8'h0D, 8'h0C},
  parameter logic [7:0]           ID_MASK        = 8'h0F,
  parameter int unsigned          TIMEOUT_CYCLES = 18000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  uart_pkt_if.slave                    i_rx,
  output logic [PAYLOAD_BYTES*8-1:0]   o_data,
  output logic [idx_w(NUM_IDS)-1:0]    o_id_index,
  output logic                         o_data_valid,
  output logic [2:0]                   o_rx_error,
  output logic                         o_rx_error_dv,
  output logic                         o_busy
`ifdef UART_PKT_STATS_EN
  ,output logic [STAT_W-1:0]           o_good_count
  ,output logic [STAT_W-1:0]           o_err_count
`endif
);

  localparam int IW = idx_w(NUM_IDS);
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam int PW = PAYLOAD_BYTES * 8;
  localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_tmo;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_acc;
  logic [7:0]      r_csum;
  logic [PW-1:0]   r_payload;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx;
  logic            w_hit;
  logic            w_acc;
  logic            w_tmo;
  logic            w_good;
  logic            w_err;
  logic [2:0]      w_code;
  logic [7:0]      w_byte;

  assign w_byte = i_rx.uart_rx_data;
  assign w_acc  = i_en & i_rx.uart_rx_valid;
  assign w_tmo  = (r_tmo >= 32'(TIMEOUT_CYCLES));

  uart_pkt_id_match #(
    .NUM_IDS (NUM_IDS),
    .IW      (IW)
  ) u_match (
    .i_byte    (w_byte),
    .i_id_list (ID_LIST),
    .i_mask    (ID_MASK),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_HEADER;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = S_HEADER;
    end else begin
      unique case (r_state)
        S_HEADER:
          if (w_acc && w_byte == HEADER) w_next = S_IDENT;
        S_IDENT:
          if (w_acc)      w_next = w_hit ? S_DATA : S_HEADER;
          else if (w_tmo) w_next = S_HEADER;
        S_DATA:
          if (w_acc) begin
            if (r_cnt == LAST) w_next = S_CSUM;
          end else if (w_tmo) begin
            w_next = S_HEADER;
          end
        S_CSUM:
          if (w_acc)      w_next = S_FOOTER;
          else if (w_tmo) w_next = S_HEADER;
        S_FOOTER:
          if (w_acc)
            w_next = (w_byte == FOOTER) ? S_CHECK : S_HEADER;
          else if (w_tmo)
            w_next = S_HEADER;
        S_CHECK:
          w_next = S_HEADER;
        default:
          w_next = S_HEADER;
      endcase
    end
  end

  always_comb begin
    o_busy = (r_state != S_HEADER);
    w_good = 1'b0;
    w_err  = 1'b0;
    w_code = ERR_NONE;
    if (i_en) begin
      unique case (r_state)
        S_IDENT:
          if (w_acc && !w_hit) begin
            w_err  = 1'b1;
            w_code = ERR_ID;
          end else if (!w_acc && w_tmo) begin
            w_err  = 1'b1;
            w_code = ERR_TIMEOUT;
          end
        S_DATA, S_CSUM:
          if (!w_acc && w_tmo) begin
            w_err  = 1'b1;
            w_code = ERR_TIMEOUT;
          end
        S_FOOTER:
          if (w_acc && w_byte != FOOTER) begin
            w_err  = 1'b1;
            w_code = ERR_FOOTER;
          end else if (!w_acc && w_tmo) begin
            w_err  = 1'b1;
            w_code = ERR_TIMEOUT;
          end
        S_CHECK:
          if (r_csum == r_acc) begin
            w_good = 1'b1;
          end else begin
            w_err  = 1'b1;
            w_code = ERR_CSUM;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmo     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_csum    <= '0;
      r_payload <= '0;
      r_idx     <= '0;
    end else if (!i_en) begin
      r_tmo <= '0;
      r_cnt <= '0;
    end else begin
      // idle-gap counter only runs inside a packet, saturating
      if (r_state == S_HEADER || r_state == S_CHECK || w_acc)
        r_tmo <= '0;
      else if (r_tmo != '1)
        r_tmo <= r_tmo + 32'd1;
      unique case (r_state)
        S_HEADER:
          if (w_acc && w_byte == HEADER) begin
            r_acc <= HEADER;
            r_cnt <= '0;
          end
        S_IDENT:
          if (w_acc && w_hit) begin
            r_acc <= r_acc ^ w_byte;
            r_idx <= w_idx;
          end
        S_DATA:
          if (w_acc) begin
            r_payload[8*r_cnt +: 8] <= w_byte;
            r_acc <= r_acc ^ w_byte;
            r_cnt <= r_cnt + 1'b1;
          end
        S_CSUM:
          if (w_acc) r_csum <= w_byte;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data        <= '0;
      o_id_index    <= '0;
      o_data_valid  <= 1'b0;
      o_rx_error    <= ERR_NONE;
      o_rx_error_dv <= 1'b0;
    end else begin
      o_data_valid  <= w_good;
      o_rx_error_dv <= w_err;
      if (w_err) o_rx_error <= w_code;
      if (w_good) begin
        o_data     <= r_payload;
        o_id_index <= r_idx;
      end
    end
  end

`ifdef UART_PKT_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_good_count <= '0;
      o_err_count  <= '0;
    end else begin
      if (o_data_valid && o_good_count != '1)
        o_good_count <= o_good_count + 1'b1;
      if (o_rx_error_dv && o_err_count != '1)
        o_err_count <= o_err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_pkt_multi_decoder.sv
// Bench for uart_pkt_multi_decoder: directed plus random packets
// against a byte-list reference model.
module tb_uart_pkt_multi_decoder;

  localparam int PB = 30;
  localparam int PW = PB * 8;
  localparam int T  = 18000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  uart_pkt_if u_rx ();

  logic [PW-1:0] o_data;
  logic [1:0]    o_id_index;
  logic          o_data_valid;
  logic [2:0]    o_rx_error;
  logic          o_rx_error_dv;
  logic          o_busy;
`ifdef UART_PKT_STATS_EN
  logic [15:0]   o_good_count;
  logic [15:0]   o_err_count;
`endif

  uart_pkt_multi_decoder #(
    .HEADER         (8'hAA),
    .FOOTER         (8'h55),
    .PAYLOAD_BYTES  (PB),
    .NUM_IDS        (4),
    .ID_LIST        ({8'h0F, 8'h0E, 8'h0D, 8'h0C}),
    .ID_MASK        (8'h0F),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_en          (en),
    .i_rx          (u_rx.slave),
    .o_data        (o_data),
    .o_id_index    (o_id_index),
    .o_data_valid  (o_data_valid),
    .o_rx_error    (o_rx_error),
    .o_rx_error_dv (o_rx_error_dv),
    .o_busy        (o_busy)
`ifdef UART_PKT_STATS_EN
    ,.o_good_count (o_good_count)
    ,.o_err_count  (o_err_count)
`endif
  );

  int tot = 0;
  int bad = 0;
  int m_good = 0;
  int m_err = 0;
  int m_both = 0;
  int exp_good = 0;
  int exp_err = 0;
  logic [PW-1:0] m_data = '0;
  logic [1:0]    m_idx = '0;
  logic [2:0]    m_code = '0;
  logic [PW-1:0] ld = '0;
  logic [7:0]    pkt[$];
  logic [7:0]    ids[4] = '{8'h0C, 8'h0D, 8'h0E, 8'h0F};

  always @(posedge clk) begin
    #1;
    if (o_data_valid) begin
      m_good++;
      m_data = o_data;
      m_idx  = o_id_index;
    end
    if (o_rx_error_dv) begin
      m_err++;
      m_code = o_rx_error;
    end
    if (o_data_valid && o_rx_error_dv) m_both++;
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    u_rx.uart_rx_data  = b;
    u_rx.uart_rx_valid = 1'b1;
    @(negedge clk);
    u_rx.uart_rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic build(input logic [7:0] id, input bit rnd,
                       input logic [7:0] cx, input logic [7:0] ft);
    logic [7:0] x;
    logic [7:0] b;
    pkt.delete();
    pkt.push_back(8'hAA);
    pkt.push_back(id);
    x = 8'hAA ^ id;
    for (int i = 0; i < PB; i++) begin
      b = rnd ? 8'($urandom) : 8'(i + 1);
      pkt.push_back(b);
      x ^= b;
    end
    pkt.push_back(x ^ cx);
    pkt.push_back(ft);
  endtask

  // kind: 1 good packet, 2 error with code
  task automatic model(input logic [7:0] p[$], output int kind,
                       output logic [2:0] code,
                       output logic [PW-1:0] d,
                       output logic [1:0] ix);
    int k;
    logic [7:0] x;
    kind = 0;
    code = 3'b000;
    d = '0;
    ix = 2'd0;
    k = -1;
    for (int i = 0; i < 4; i++)
      if (k < 0 && ((p[1] & 8'h0F) == (ids[i] & 8'h0F))) k = i;
    if (k < 0) begin
      kind = 2;
      code = 3'b100;
      return;
    end
    x = 8'hAA;
    for (int i = 1; i <= PB + 1; i++) x ^= p[i];
    if (p[PB+3] != 8'h55) begin
      kind = 2;
      code = 3'b010;
    end else if (p[PB+2] != x) begin
      kind = 2;
      code = 3'b001;
    end else begin
      kind = 1;
      for (int i = 0; i < PB; i++) d[8*i +: 8] = p[i+2];
      ix = 2'(k);
    end
  endtask

  task automatic run(input int maxgap, input int sidx, input int slen);
    int kind;
    int g0;
    int e0;
    int gap;
    logic [2:0] code;
    logic [PW-1:0] d;
    logic [1:0] ix;
    model(pkt, kind, code, d, ix);
    if (kind == 2 && code == 3'b100)
      while (pkt.size() > 2) void'(pkt.pop_back());
    g0 = m_good;
    e0 = m_err;
    foreach (pkt[i]) begin
      if (i == pkt.size() - 1) gap = 0;
      else if (i == sidx)      gap = slen;
      else                     gap = int'($urandom_range(0, maxgap));
      send(pkt[i], gap);
    end
    if (kind == 2 && code != 3'b001)
      chk("err_lat", {255'd0, o_rx_error_dv}, 256'd1);
    @(negedge clk);
    if (kind == 1)
      chk("good_lat", {255'd0, o_data_valid}, 256'd1);
    if (kind == 2 && code == 3'b001)
      chk("csum_lat", {255'd0, o_rx_error_dv}, 256'd1);
    repeat (2) @(negedge clk);
    chk("good_n", 256'(m_good - g0), 256'(kind == 1));
    chk("err_n", 256'(m_err - e0), 256'(kind == 2));
    if (kind == 1) begin
      ld = d;
      exp_good++;
      chk("data", 256'(m_data), 256'(d));
      chk("idx", 256'(m_idx), 256'(ix));
    end
    if (kind == 2) begin
      exp_err++;
      chk("code", 256'(m_code), 256'(code));
      chk("code_hold", 256'(o_rx_error), 256'(code));
      chk("data_hold", 256'(o_data), 256'(ld));
    end
  endtask

  initial begin
    int e0;
    int g0;
    int r;
    logic [7:0] id;
    logic [7:0] cx;
    logic [7:0] ft;
    u_rx.uart_rx_data  = 8'h00;
    u_rx.uart_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 256'(o_data), 256'd0);
    chk("rst_idx", 256'(o_id_index), 256'd0);
    chk("rst_dv", 256'(o_data_valid), 256'd0);
    chk("rst_err", 256'(o_rx_error), 256'd0);
    chk("rst_edv", 256'(o_rx_error_dv), 256'd0);
    chk("rst_busy", 256'(o_busy), 256'd0);
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);

    build(8'h0D, 1'b0, 8'h00, 8'h55);
    run(0, -1, 0);
    chk("p1_lo", 256'(m_data[7:0]), 256'h01);
    chk("p1_hi", 256'(m_data[239:232]), 256'h1E);
    chk("p1_idx", 256'(m_idx), 256'd1);

    build(8'h0D, 1'b0, 8'h01, 8'h55);
    run(0, -1, 0);

    build(8'h0C, 1'b1, 8'h00, 8'h54);
    run(1, -1, 0);

    build(8'h07, 1'b1, 8'h00, 8'h55);
    run(0, -1, 0);

    send(8'hAA, 0);
    send(8'h0C, 0);
    send(8'h01, 0);
    e0 = m_err;
    repeat (T) @(negedge clk);
    chk("tmo_busy_pre", 256'(o_busy), 256'd1);
    chk("tmo_pre", 256'(m_err - e0), 256'd0);
    @(negedge clk);
    chk("tmo_dv", 256'(o_rx_error_dv), 256'd1);
    chk("tmo_code", 256'(o_rx_error), 256'd3);
    chk("tmo_busy", 256'(o_busy), 256'd0);
    exp_err++;
    @(negedge clk);

    build(8'h0C, 1'b0, 8'h00, 8'h55);
    run(0, 2, T);

    build(8'h0D, 1'b1, 8'h00, 8'h55);
    for (int i = 0; i < 7; i++) send(pkt[i], 0);
    e0 = m_err;
    g0 = m_good;
    en = 1'b0;
    @(negedge clk);
    chk("en_busy", 256'(o_busy), 256'd0);
    send(8'hAA, 0);
    send(8'h0C, 0);
    chk("en_busy2", 256'(o_busy), 256'd0);
    repeat (2) @(negedge clk);
    chk("en_err", 256'(m_err - e0), 256'd0);
    chk("en_good", 256'(m_good - g0), 256'd0);
    en = 1'b1;
    @(negedge clk);
    build(8'h0E, 1'b1, 8'h00, 8'h55);
    run(1, -1, 0);

    build(8'h0F, 1'b1, 8'h00, 8'h55);
    for (int i = 0; i < 5; i++) send(pkt[i], 0);
    e0 = m_err;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 256'(o_busy), 256'd0);
    chk("mrst_data", 256'(o_data), 256'd0);
    chk("mrst_edv", 256'(o_rx_error_dv), 256'd0);
    chk("mrst_err", 256'(m_err - e0), 256'd0);
    rst_n = 1'b1;
    ld = '0;
    exp_good = 0;
    exp_err = 0;
    @(negedge clk);

    for (int n = 0; n < 25; n++) begin
      r = int'($urandom_range(0, 5));
      if (r < 4) id = {4'($urandom), ids[r][3:0]};
      else       id = {4'($urandom), 4'($urandom_range(0, 11))};
      cx = ($urandom_range(0, 3) == 0) ?
           8'($urandom_range(1, 255)) : 8'h00;
      ft = ($urandom_range(0, 4) == 0) ? 8'h5A : 8'h55;
      build(id, 1'b1, cx, ft);
      run(3, -1, 0);
    end

    chk("no_overlap", 256'(m_both), 256'd0);
`ifdef UART_PKT_STATS_EN
    chk("stat_good", 256'(o_good_count), 256'(exp_good));
    chk("stat_err", 256'(o_err_count), 256'(exp_err));
`endif
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
